bin2bcd_seq: RTL

- Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble). It sits directly downstream of the 8-bit up/down counter.
- Takes the counter's `count` value on a start strobe and produces packed BCD digits for the 7-segment / hex display stage.
- Uses one iteration per clock, trading latency for minimal logic.

---
 rtl/bin2bcd_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per clock.
// Accepts a binary value on start and presents packed BCD digits with a one-cycle done pulse.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_bin;
  logic [SW-1:0]    r_scratch;
  logic [CW-1:0]    r_cnt;
  logic [SW-1:0]    r_bcd;
  logic             r_done;
  logic             r_ready;
  logic             r_busy;

  logic [SW-1:0]    w_adj;
  logic [SW-1:0]    w_scratch_sh;
  logic [WIDTH-1:0] w_bin_sh;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Per-digit add-3 correction, then one-bit shift of {scratch, binary}
  always_comb begin
    w_adj = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      end else begin
        w_adj[4*d +: 4] = r_scratch[4*d +: 4];
      end
    end
    w_scratch_sh = {w_adj[SW-2:0], r_bin[WIDTH-1]};
    w_bin_sh     = {r_bin[WIDTH-2:0], 1'b0};
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_done  <= w_last;
      r_ready <= (w_state_nxt == IDLE);
      r_busy  <= (w_state_nxt == SHIFT);
      if (w_accept) begin
        r_bin     <= bin;
        r_scratch <= '0;
        r_cnt     <= '0;
      end else if (r_state == SHIFT) begin
        r_bin     <= w_bin_sh;
        r_scratch <= w_scratch_sh;
        r_cnt     <= r_cnt + CW'(1);
      end
      // Result is published only once the final iteration completes
      if (w_last) begin
        r_bcd <= w_scratch_sh;
      end
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign bcd   = r_bcd;

endmodule
